// File: rtl/skid_register_slice_if.sv
// Valid/ready handshake bundle around the skid register slice.
// The slave view belongs to the slice, and the master view belongs to whatever drives it.
interface skid_register_slice_if #(
  parameter int WIDTH = 8
);
  logic             src_vaild;
  logic [WIDTH-1:0] src_data_in;
  logic             src_ready;
  logic             dst_vaild;
  logic [WIDTH-1:0] dst_data_out;
  logic             dst_ready;

  modport slave (
    input  src_vaild, src_data_in, dst_ready,
    output src_ready, dst_vaild, dst_data_out
  );

  modport master (
    output src_vaild, src_data_in, dst_ready,
    input  src_ready, dst_vaild, dst_data_out
  );
endinterface

// File: rtl/skid_register_slice.sv
// Fully registered valid/ready pipeline slice: a main register plus one skid register.
// Both src_ready and dst_vaild come from flops, so ready and valid never form a combinational path.
module skid_register_slice #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 s_rst,
  skid_register_slice_if.slave bus,
  input  logic                 clr_cnt,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     xfer_cnt
);

  // The encoding is the occupancy value, so occupancy can be read directly from the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             src_ready_q;
  logic             dst_vaild_q;
  logic             accept;
  logic             deliver;

  assign accept  = bus.src_vaild & src_ready_q;
  assign deliver = dst_vaild_q & bus.dst_ready;

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = bus.src_data_in;
        end
      end
      BUSY: begin
        if (accept && !deliver) begin
          state_d = FULL;
          skid_d  = bus.src_data_in;
        end else if (accept && deliver) begin
          main_d  = bus.src_data_in;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q     <= EMPTY;
      src_ready_q <= 1'b0;
      dst_vaild_q <= 1'b0;
      // NOTE: the data registers are reset too, so dst_data_out reads 0 instead of stale data.
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ready_q <= (state_d != FULL);
      dst_vaild_q <= (state_d != EMPTY);
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  // clr_cnt wins over a coincident handshake.
  always_ff @(posedge clk) begin
    if (s_rst || clr_cnt) begin
      xfer_cnt <= '0;
    end else if (deliver) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.src_ready    = src_ready_q;
  assign bus.dst_vaild    = dst_vaild_q;
  assign bus.dst_data_out = main_q;
  assign occupancy        = state_q;

endmodule

// File: tb/tb_skid_register_slice.sv
// Directed vector table plus scoreboard-checked sequences for skid_register_slice.
// CNT_W is 4 so that counter wrap can be reached quickly.
module tb_skid_register_slice;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             s_rst;
  logic             clr_cnt;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  skid_register_slice_if #(.WIDTH(WIDTH)) bus ();

  skid_register_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .s_rst     (s_rst),
    .bus       (bus.slave),
    .clr_cnt   (clr_cnt),
    .occupancy (occupancy),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] d;
    logic       dr;
    logic       clr;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [1:0] e_occ;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t       vecs[16];
  logic [7:0] sb_q[$];
  logic [3:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [7:0] d, input logic dr);
    bus.src_vaild   = sv;
    bus.src_data_in = d;
    bus.dst_ready   = dr;
  endtask

  // One cycle against the reference FIFO: handshakes are decided from pre-edge outputs.
  task automatic sb_cycle(input logic sv, input logic [7:0] d, input logic dr);
    logic acc, del;
    drive(sv, d, dr);
    acc = sv && bus.src_ready;
    del = bus.dst_vaild && dr;
    if (del) begin
      if (sb_q.size() == 0) check("sb_spurious_beat", 32'(bus.dst_vaild), 32'(0));
      else begin
        check("sb_data", 32'(bus.dst_data_out), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      exp_cnt = exp_cnt + 4'd1;
    end
    if (acc) sb_q.push_back(d);
    tick();
    check("sb_occupancy", 32'(occupancy), 32'(sb_q.size()));
    check("sb_src_ready", 32'(bus.src_ready), 32'(sb_q.size() < 2));
    check("sb_dst_vaild", 32'(bus.dst_vaild), 32'(sb_q.size() != 0));
    check("sb_xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    if (occupancy == 2'd3) check("sb_occ_range", 32'(occupancy), 32'(2));
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    s_rst = 1'b0;
    sb_q.delete();
    exp_cnt = '0;
  endtask

  initial begin
    logic r0, v0;
    s_rst   = 1'b1;
    clr_cnt = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    //          rst  sv   d      dr   clr  rdy  vld  dat    occ  cnt
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,8'h00,2'd0,4'd0};
    vecs[1]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,2'd0,4'd0};
    vecs[2]  = '{1'b0,1'b1,8'hA1,1'b0,1'b0,1'b1,1'b1,8'hA1,2'd1,4'd0};
    vecs[3]  = '{1'b0,1'b1,8'hA2,1'b0,1'b0,1'b0,1'b1,8'hA1,2'd2,4'd0};
    vecs[4]  = '{1'b0,1'b1,8'hA3,1'b0,1'b0,1'b0,1'b1,8'hA1,2'd2,4'd0};
    vecs[5]  = '{1'b0,1'b1,8'hA4,1'b1,1'b0,1'b1,1'b1,8'hA2,2'd1,4'd1};
    vecs[6]  = '{1'b0,1'b1,8'hA5,1'b1,1'b0,1'b1,1'b1,8'hA5,2'd1,4'd2};
    vecs[7]  = '{1'b0,1'b0,8'hFF,1'b1,1'b0,1'b1,1'b0,8'hA5,2'd0,4'd3};
    vecs[8]  = '{1'b0,1'b0,8'hEE,1'b1,1'b0,1'b1,1'b0,8'hA5,2'd0,4'd3};
    vecs[9]  = '{1'b0,1'b1,8'hB1,1'b1,1'b1,1'b1,1'b1,8'hB1,2'd1,4'd0};
    vecs[10] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,8'hB1,2'd0,4'd0};
    vecs[11] = '{1'b0,1'b1,8'hC1,1'b0,1'b0,1'b1,1'b1,8'hC1,2'd1,4'd0};
    vecs[12] = '{1'b0,1'b1,8'hC2,1'b0,1'b0,1'b0,1'b1,8'hC1,2'd2,4'd0};
    vecs[13] = '{1'b1,1'b1,8'hC3,1'b1,1'b0,1'b0,1'b0,8'h00,2'd0,4'd0};
    vecs[14] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,8'h00,2'd0,4'd0};
    vecs[15] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,8'h00,2'd0,4'd0};

    for (int i = 0; i < 16; i++) begin
      s_rst   = vecs[i].rst;
      clr_cnt = vecs[i].clr;
      drive(vecs[i].sv, vecs[i].d, vecs[i].dr);
      tick();
      check($sformatf("vec%0d_src_ready", i), 32'(bus.src_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_dst_vaild", i), 32'(bus.dst_vaild), 32'(vecs[i].e_vld));
      check($sformatf("vec%0d_dst_data", i), 32'(bus.dst_data_out), 32'(vecs[i].e_dat));
      check($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      check($sformatf("vec%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(vecs[i].e_cnt));
    end
    s_rst   = 1'b0;
    clr_cnt = 1'b0;

    // Streaming 0x01..0x10, one beat per cycle, visible one cycle after its accept.
    clr_cnt = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 1), 1'b1);
      tick();
      check("stream_dst_vaild", 32'(bus.dst_vaild), 32'(1));
      check("stream_data", 32'(bus.dst_data_out), 32'(i + 1));
      check("stream_src_ready", 32'(bus.src_ready), 32'(1));
      check("stream_cnt", 32'(xfer_cnt), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("stream_drained", 32'(bus.dst_vaild), 32'(0));
    check("stream_cnt_wrap16", 32'(xfer_cnt), 32'(0));
    // A 17th delivery leaves the 4-bit counter at 1.
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("cnt_after_17", 32'(xfer_cnt), 32'(1));

    // While src_vaild is held, toggling dst_ready mid-cycle must not move src_ready,
    // and toggling src_vaild mid-cycle must not move dst_vaild.
    drive(1'b1, 8'h55, 1'b0);
    tick();
    r0 = bus.src_ready;
    v0 = bus.dst_vaild;
    for (int k = 0; k < 4; k++) begin
      #1 bus.dst_ready = ~bus.dst_ready;
      #1 check("struct_src_ready", 32'(bus.src_ready), 32'(r0));
    end
    for (int k = 0; k < 2; k++) begin
      #1 bus.src_vaild = ~bus.src_vaild;
      #1 check("struct_dst_vaild", 32'(bus.dst_vaild), 32'(v0));
    end

    // Three-cycle downstream stall absorbed by the skid register.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb_cycle(1'b1, 8'(8'h40 + i), !(i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) begin
        check("stall_occupancy", 32'(occupancy), 32'(2));
        check("stall_src_ready", 32'(bus.src_ready), 32'(0));
        check("stall_data_held", 32'(bus.dst_data_out), 32'(8'h42));
      end
    end
    for (int i = 0; i < 3; i++) sb_cycle(1'b0, 8'h00, 1'b1);
    check("stall_no_loss", 32'(sb_q.size()), 32'(0));

    // Random handshakes against the reference FIFO.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      sb_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset while FULL: the stored beats vanish and the skid beat never appears.
    sb_cycle(1'b1, 8'hD1, 1'b0);
    sb_cycle(1'b1, 8'hD2, 1'b0);
    sb_cycle(1'b1, 8'hD3, 1'b0);
    check("rstfull_pre_occ", 32'(occupancy), 32'(2));
    s_rst = 1'b1;
    drive(1'b1, 8'hD4, 1'b1);
    tick();
    s_rst = 1'b0;
    check("rstfull_occ", 32'(occupancy), 32'(0));
    check("rstfull_vld", 32'(bus.dst_vaild), 32'(0));
    check("rstfull_data", 32'(bus.dst_data_out), 32'(0));
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstfull_no_skid_beat", 32'(bus.dst_vaild), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/skid_register_slice.md
SKID_REGISTER_SLICE -- requirements
Module: skid_register_slice

Interface
REQ-001 Parameter WIDTH, default 8, payload width in bits.
REQ-002 Parameter CNT_W, default 16, width of the delivered-beat counter.
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 s_rst  input  1  reset, synchronous, active-high.
REQ-005 src_vaild  input  1  upstream beat valid.
REQ-006 src_data_in  input  WIDTH  upstream payload.
REQ-007 src_ready  output  1  slice can accept a beat this cycle; driven directly from a flop.
REQ-008 dst_vaild  output  1  downstream beat valid; driven directly from a flop.
REQ-009 dst_data_out  output  WIDTH  downstream payload; driven directly from the main register.
REQ-010 dst_ready  input  1  downstream accepts the beat.
REQ-011 clr_cnt  input  1  synchronous clear of xfer_cnt.
REQ-012 occupancy  output  2  number of stored beats: 0, 1 or 2.
REQ-013 xfer_cnt  output  CNT_W  count of completed downstream handshakes.

Function
REQ-014 The slice SHALL accept a beat only on cycles where src_vaild & src_ready, and SHALL deliver a beat only on cycles where dst_vaild & dst_ready.
REQ-015 Storage SHALL be a main register, which drives dst_data_out, plus one skid register.
REQ-016 The FSM SHALL have three states: EMPTY (occupancy 0), BUSY (occupancy 1, main valid), FULL (occupancy 2, main and skid valid).
REQ-017 EMPTY: on accept -> BUSY, main <= src_data_in; otherwise stay.
REQ-018 BUSY, accept & !deliver -> FULL, skid <= src_data_in.
REQ-019 BUSY, !accept & deliver -> EMPTY.
REQ-020 BUSY, accept & deliver -> BUSY, main <= src_data_in.
REQ-021 BUSY, neither accept nor deliver -> stay in BUSY.
REQ-022 FULL: on deliver -> BUSY, main <= skid; otherwise stay. src_ready is 0 in FULL, so no accept occurs.
REQ-023 src_ready SHALL be 1 in EMPTY and BUSY, and 0 in FULL, registered from the next-state value.
REQ-024 dst_vaild SHALL be 1 in BUSY and FULL, registered from the next-state value.
REQ-025 Latency SHALL be 1 cycle: a beat accepted at edge N appears on dst_vaild/dst_data_out after edge N.
REQ-026 Sustained throughput SHALL be 1 beat per cycle when dst_ready=1 continuously.
REQ-027 Ordering SHALL be strict FIFO; no beat may be dropped or duplicated.
REQ-028 While dst_vaild & !dst_ready, dst_data_out SHALL hold constant.
REQ-029 A downstream stall SHALL be absorbed by the skid register with at most one extra beat accepted; src_ready deasserts the cycle after the skid fills.
REQ-030 occupancy SHALL equal the FSM state encoding 0/1/2 and SHALL never read 3.
REQ-031 xfer_cnt SHALL increment by 1 per downstream handshake and wrap modulo 2^CNT_W.
REQ-032 When clr_cnt coincides with a handshake, xfer_cnt SHALL become 0 (clr has priority).
REQ-033 src_data_in SHALL be ignored whenever no accept occurs, including when src_vaild=1 in FULL.
REQ-034 No combinational path SHALL exist from dst_ready to src_ready or from src_vaild to dst_vaild.

Reset
REQ-035 With s_rst=1 at a clock edge, the next state SHALL be EMPTY, with src_ready=0, dst_vaild=0, occupancy=0 and xfer_cnt=0.
REQ-036 The first cycle after reset release SHALL give src_ready=1.
REQ-037 Main and skid data registers SHALL also reset to 0, so dst_data_out=0 after reset.
REQ-038 Reset asserted mid-operation, including in FULL, SHALL discard all stored beats, with no delivery on the reset cycle.

Verification
REQ-039 Streaming: src_vaild=1 with data 0x01..0x10 and dst_ready=1 -> 16 beats out in order, one per cycle starting 1 cycle after the first accept; xfer_cnt=16.
REQ-040 Stall: dst_ready=0 for 3 cycles mid-stream -> occupancy rises to 2, src_ready=0, dst_data_out held; after release, no loss and order preserved.
REQ-041 Random: random src_vaild/dst_ready for 10k cycles, checked against a reference FIFO scoreboard -> zero mismatches, and occupancy always within 0..2.
REQ-042 Counter: CNT_W=4 with 17 deliveries -> xfer_cnt=1; clr_cnt asserted together with a handshake -> xfer_cnt=0 next cycle.
REQ-043 Reset in FULL: s_rst pulsed while occupancy=2 -> next cycle occupancy=0, dst_vaild=0, dst_data_out=0, and the skid beat is never delivered.
REQ-044 Structural check: dst_ready toggled with src_vaild held constant -> src_ready changes only on clock edges, never within a cycle.
